// File: rtl/riscv_pkg.sv
// Shared definitions for the pipeline hazard controller: register address
// width, default performance-counter width and the controller state encoding.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int CNT_W_DEF  = 32;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter
    import riscv_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // count enabled cycles, holding once the maximum is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= sat_inc(r_cnt);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage RISC-V pipeline: load-use interlock,
// redirect flushing, memory-wait freezing and debug drain/halt sequencing.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1_D,
    input  logic [REG_ADDR_W-1:0] rs2_D,
    input  logic                  use_rs2_D,
    input  logic [REG_ADDR_W-1:0] rd_E,
    input  logic                  MemReadEn_E,
    input  logic                  redirect_E,
    input  logic                  mem_busy_M,
    input  logic                  halt_req,
    output logic                  stall_F,
    output logic                  stall_D,
    output logic                  stall_E,
    output logic                  stall_M,
    output logic                  flush_D,
    output logic                  flush_E,
    output logic                  bubble_W,
    output logic                  halt_ack,
    output logic [1:0]            state_o,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    hz_state_e r_state;
    hz_state_e w_next;
    hz_state_e r_ret;
    hz_state_e w_ret_next;
    logic      r_valid_D;
    logic      r_valid_E;
    logic      r_valid_M;
    logic      r_halt_ack;

    logic w_load_use;
    logic w_redirect;
    logic w_drain_mode;
    logic w_redirect_flush;
    logic w_cnt_stall_en;
    logic w_stall_F;
    logic w_stall_D;
    logic w_stall_E;
    logic w_stall_M;
    logic w_flush_D;
    logic w_flush_E;
    logic w_bubble_W;

    // x0 never carries a dependency and empty stages never create hazards
    assign w_load_use = r_valid_E && r_valid_D && MemReadEn_E && (rd_E != '0) &&
                        ((rd_E == rs1_D) || (use_rs2_D && (rd_E == rs2_D)));
    assign w_redirect = redirect_E && r_valid_E;

    // next-state and Mealy hazard outputs; a memory stall overrides everything,
    // which keeps a coincident branch parked in EX until memory releases
    always_comb begin
        w_next           = r_state;
        w_ret_next       = r_ret;
        w_stall_F        = 1'b0;
        w_stall_D        = 1'b0;
        w_stall_E        = 1'b0;
        w_stall_M        = 1'b0;
        w_flush_D        = 1'b0;
        w_flush_E        = 1'b0;
        w_bubble_W       = 1'b0;
        w_redirect_flush = 1'b0;
        w_drain_mode     = (r_state == ST_DRAIN) ||
                           ((r_state == ST_MEM_WAIT) && (r_ret == ST_DRAIN));
        case (r_state)
            ST_RUN, ST_DRAIN, ST_MEM_WAIT: begin
                if (mem_busy_M) begin
                    w_stall_F  = 1'b1;
                    w_stall_D  = 1'b1;
                    w_stall_E  = 1'b1;
                    w_stall_M  = 1'b1;
                    w_bubble_W = 1'b1;
                    w_next     = ST_MEM_WAIT;
                    if (r_state != ST_MEM_WAIT) begin
                        w_ret_next = r_state;
                    end
                end else begin
                    // the release cycle of MEM_WAIT already behaves like the
                    // state it returns to, so a held redirect is acted on here
                    if (w_redirect) begin
                        w_flush_D        = 1'b1;
                        w_flush_E        = 1'b1;
                        w_redirect_flush = 1'b1;
                    end else if (w_load_use) begin
                        w_stall_F = 1'b1;
                        w_stall_D = 1'b1;
                        w_flush_E = 1'b1;
                    end
                    if (w_drain_mode) begin
                        w_stall_F = 1'b1;
                        w_flush_D = 1'b1;
                    end
                    case (r_state)
                        ST_MEM_WAIT: w_next = r_ret;
                        ST_RUN: begin
                            if (halt_req) begin
                                w_next = ST_DRAIN;
                            end
                        end
                        default: begin
                            if (!halt_req) begin
                                w_next = ST_RUN;
                            end else if (!r_valid_D && !r_valid_E && !r_valid_M) begin
                                w_next = ST_HALTED;
                            end
                        end
                    endcase
                end
            end
            default: begin
                w_stall_F = 1'b1;
                w_stall_D = 1'b1;
                if (!halt_req) begin
                    w_next = ST_RUN;
                end
            end
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // MEM_WAIT return target and registered halt acknowledge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ret      <= ST_RUN;
            r_halt_ack <= 1'b0;
        end else begin
            r_ret      <= w_ret_next;
            r_halt_ack <= (w_next == ST_HALTED);
        end
    end

    // stage occupancy; a stalled stage keeps its bit, stall wins over flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid_D <= 1'b0;
            r_valid_E <= 1'b0;
            r_valid_M <= 1'b0;
        end else begin
            if (!w_stall_D) begin
                r_valid_D <= !w_stall_F && !w_flush_D;
            end
            if (!w_stall_E) begin
                r_valid_E <= r_valid_D && !w_flush_E;
            end
            if (!w_stall_M) begin
                r_valid_M <= r_valid_E;
            end
        end
    end

    assign w_cnt_stall_en = w_stall_D && ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT));

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .i_en  (w_cnt_stall_en),
        .o_cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (reset),
        .i_en  (w_redirect_flush),
        .o_cnt (flush_cnt)
    );

    // combinational controls are forced low while reset is held
    assign stall_F  = w_stall_F  & reset;
    assign stall_D  = w_stall_D  & reset;
    assign stall_E  = w_stall_E  & reset;
    assign stall_M  = w_stall_M  & reset;
    assign flush_D  = w_flush_D  & reset;
    assign flush_E  = w_flush_E  & reset;
    assign bubble_W = w_bubble_W & reset;
    assign halt_ack = r_halt_ack;
    assign state_o  = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios followed by random traffic,
// every cycle compared against a pipeline-occupancy reference model.
module tb_hazard_ctrl;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    rs1_D, rs2_D, rd_E;
    logic          use_rs2_D, MemReadEn_E, redirect_E, mem_busy_M, halt_req;
    logic          stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, bubble_W, halt_ack;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    // reference model: which stages hold a live instruction and what mode we are in
    bit occD, occE, occM;
    bit halted, draining, waiting, ret_drain;
    int mstall, mflush;
    bit eF, eD, eE, eM, efD, efE, eBW, br_eff;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .rs1_D       (rs1_D),
        .rs2_D       (rs2_D),
        .use_rs2_D   (use_rs2_D),
        .rd_E        (rd_E),
        .MemReadEn_E (MemReadEn_E),
        .redirect_E  (redirect_E),
        .mem_busy_M  (mem_busy_M),
        .halt_req    (halt_req),
        .stall_F     (stall_F),
        .stall_D     (stall_D),
        .stall_E     (stall_E),
        .stall_M     (stall_M),
        .flush_D     (flush_D),
        .flush_E     (flush_E),
        .bubble_W    (bubble_W),
        .halt_ack    (halt_ack),
        .state_o     (state_o),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    task automatic idle();
        rs1_D = 5'd0; rs2_D = 5'd0; rd_E = 5'd0; use_rs2_D = 1'b0;
        MemReadEn_E = 1'b0; redirect_E = 1'b0; mem_busy_M = 1'b0; halt_req = 1'b0;
    endtask

    task automatic model_reset();
        occD = 0; occE = 0; occM = 0;
        halted = 0; draining = 0; waiting = 0; ret_drain = 0;
        mstall = 0; mflush = 0;
    endtask

    function automatic int exp_state();
        if (halted)   return 3;
        if (waiting)  return 1;
        if (draining) return 2;
        return 0;
    endfunction

    // expected controls for this cycle from the hazard rules
    task automatic model_eval();
        bit lu, br, dm;
        {eF, eD, eE, eM, efD, efE, eBW, br_eff} = '0;
        if (halted) begin
            eF = 1; eD = 1;
        end else if (mem_busy_M) begin
            eF = 1; eD = 1; eE = 1; eM = 1; eBW = 1;
        end else begin
            lu = occE && occD && MemReadEn_E && (rd_E != 0) &&
                 ((rd_E == rs1_D) || (use_rs2_D && (rd_E == rs2_D)));
            br = redirect_E && occE;
            if (br) begin
                efD = 1; efE = 1; br_eff = 1;
            end else if (lu) begin
                eF = 1; eD = 1; efE = 1;
            end
            dm = waiting ? ret_drain : draining;
            if (dm) begin
                eF = 1; efD = 1;
            end
        end
    endtask

    // advance the model across one clock edge
    task automatic model_step();
        bit nD, nE, nM, empty;
        if (eD && !halted && (waiting || !draining) && mstall < CMAX) mstall++;
        if (br_eff && mflush < CMAX) mflush++;
        nM = eM ? occM : occE;
        nE = eE ? occE : (occD && !efE);
        nD = eD ? occD : (!eF && !efD);
        empty = !occD && !occE && !occM;
        if (halted) begin
            if (!halt_req) halted = 0;
        end else if (mem_busy_M) begin
            if (!waiting) begin
                waiting = 1; ret_drain = draining;
            end
        end else if (waiting) begin
            waiting = 0; draining = ret_drain;
        end else if (draining) begin
            if (!halt_req) draining = 0;
            else if (empty) begin
                draining = 0; halted = 1;
            end
        end else if (halt_req) begin
            draining = 1;
        end
        occD = nD; occE = nE; occM = nM;
    endtask

    task automatic check(input string tag);
        logic [9:0] obs, expv;
        obs  = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, bubble_W, halt_ack, state_o};
        expv = {eF, eD, eE, eM, efD, efE, eBW, halted, 2'(exp_state())};
        total++;
        assert (obs === expv) else begin
            bad++; $error("FAIL %s ctl got=%b want=%b", tag, obs, expv);
        end
        total++;
        assert (stall_cnt === CW'(mstall)) else begin
            bad++; $error("FAIL %s stall_cnt got=%0d want=%0d", tag, stall_cnt, mstall);
        end
        total++;
        assert (flush_cnt === CW'(mflush)) else begin
            bad++; $error("FAIL %s flush_cnt got=%0d want=%0d", tag, flush_cnt, mflush);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++; $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // one clock: check mid-low-phase, then step the model on the edge
    task automatic tick(input string tag);
        #1;
        model_eval();
        check(tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // asynchronous reset pulse starting mid-cycle; ends at a negedge, released
    task automatic rst_pulse(input string tag);
        #2 reset = 1'b0;
        model_reset();
        #1;
        expect_val({tag, "_rst_ctl"},
                   {22'd0, stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
                    bubble_W, halt_ack, state_o}, 32'd0);
        expect_val({tag, "_rst_cnt"}, {24'd0, stall_cnt, flush_cnt}, 32'd0);
        idle();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int drain_at, ack_at;
        reset = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        rst_pulse("init");

        // load-use: lw x5 in EX, add x6,x5,x7 in ID
        rst_pulse("lu");
        tick("lu_fill"); tick("lu_fill");
        rd_E = 5'd5; MemReadEn_E = 1'b1; rs1_D = 5'd5; rs2_D = 5'd7; use_rs2_D = 1'b1;
        #1 expect_val("lu_stall", {stall_F, stall_D, flush_E}, 3'b111);
        tick("lu_hit");
        #1 expect_val("lu_release", {stall_F, stall_D, flush_E}, 3'b000);
        tick("lu_after");
        idle();
        tick("lu_idle");
        expect_val("lu_cnt", stall_cnt, 1);

        // load to x0 never interlocks
        rst_pulse("x0");
        tick("x0_fill"); tick("x0_fill");
        rd_E = 5'd0; MemReadEn_E = 1'b1; rs1_D = 5'd0;
        #1 expect_val("x0_nostall", {stall_F, stall_D, flush_E}, 3'b000);
        tick("x0_hit");
        idle();
        tick("x0_idle");
        expect_val("x0_cnt", stall_cnt, 0);

        // redirect beats a simultaneous load-use
        rst_pulse("rd");
        tick("rd_fill"); tick("rd_fill");
        rd_E = 5'd5; MemReadEn_E = 1'b1; rs1_D = 5'd5; redirect_E = 1'b1;
        #1 expect_val("rd_ctl", {flush_D, flush_E, stall_D, stall_F}, 4'b1100);
        tick("rd_hit");
        idle();
        tick("rd_idle");
        expect_val("rd_fcnt", flush_cnt, 1);
        expect_val("rd_scnt", stall_cnt, 0);

        // three busy cycles in memory
        rst_pulse("mb");
        tick("mb_fill"); tick("mb_fill");
        mem_busy_M = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 expect_val("mb_stall", {stall_F, stall_D, stall_E, stall_M, bubble_W}, 5'b11111);
            tick("mb_busy");
        end
        mem_busy_M = 1'b0;
        tick("mb_release");
        #1 expect_val("mb_state", state_o, 0);
        expect_val("mb_cnt", stall_cnt, 3);
        tick("mb_idle");

        // redirect arriving under a memory stall is deferred, then taken
        redirect_E = 1'b1; mem_busy_M = 1'b1;
        #1 expect_val("def_held", {flush_D, flush_E}, 2'b00);
        tick("def_busy");
        tick("def_busy");
        mem_busy_M = 1'b0;
        #1 expect_val("def_taken", {flush_D, flush_E}, 2'b11);
        tick("def_take");
        idle();
        tick("def_idle");

        // halt with a full pipeline
        rst_pulse("hl");
        tick("hl_fill"); tick("hl_fill"); tick("hl_fill");
        halt_req = 1'b1;
        drain_at = -1; ack_at = -1;
        for (int i = 0; i < 10; i++) begin
            tick("hl_drain");
            if (state_o == 2'd2 && drain_at < 0) drain_at = i;
            if (halt_ack === 1'b1 && ack_at < 0) ack_at = i;
        end
        expect_val("hl_ack_seen", (ack_at >= 0 && drain_at >= 0 && (ack_at - drain_at) <= 4), 1);
        halt_req = 1'b0;
        tick("hl_release");
        #1 expect_val("hl_state", state_o, 0);
        expect_val("hl_ack_low", halt_ack, 0);
        tick("hl_run");

        // counter saturation, then a reset in the middle of a drain
        rst_pulse("sat");
        mem_busy_M = 1'b1;
        repeat (20) tick("sat_busy");
        mem_busy_M = 1'b0;
        tick("sat_rel");
        expect_val("sat_stall", stall_cnt, CMAX);
        redirect_E = 1'b1;
        repeat (60) tick("sat_redir");
        redirect_E = 1'b0;
        tick("sat_idle");
        expect_val("sat_flush", flush_cnt, CMAX);
        halt_req = 1'b1;
        tick("sat_halt"); tick("sat_halt");
        expect_val("sat_in_drain", state_o, 2);
        rst_pulse("sat_mid");
        for (int i = 0; i < 6; i++) begin
            tick("sat_post");
            expect_val("sat_noack", halt_ack, 0);
        end

        // random traffic against the model
        for (int n = 0; n < 500; n++) begin
            rs1_D       = 5'($urandom_range(0, 3));
            rs2_D       = 5'($urandom_range(0, 3));
            rd_E        = 5'($urandom_range(0, 3));
            use_rs2_D   = ($urandom_range(0, 1) == 1);
            MemReadEn_E = ($urandom_range(0, 99) < 40);
            redirect_E  = ($urandom_range(0, 99) < 15);
            mem_busy_M  = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 99) < 6) halt_req = ~halt_req;
            if ($urandom_range(0, 199) == 0) rst_pulse("rnd");
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
